// File: rtl/dfm_core.sv
// dfm_core: frequency meter core with SPI command decoder, gated reciprocal counter and byte
// register file. Define DFM_SIG_SYNC_EN to place a 2-FF synchronizer on sig_clk_i.
module dfm_core #(
  parameter logic [7:0]  CMD_CONF_WR   = 8'h2A,
  parameter logic [7:0]  CMD_REG_RD    = 8'h3A,
  parameter logic [31:0] GATE_TIME_RST = 32'd0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        dc_i,
  input  logic        spi_byte_vld_i,
  input  logic [7:0]  spi_byte_data_i,
  input  logic        sig_clk_i,
  output logic [7:0]  reg_rd_data_o,
  output logic [31:0] reg_gate_time_o
);

  typedef enum logic [1:0] {StIdle, StConfWr, StRegRd} cmd_state_e;
  typedef enum logic [1:0] {MeasIdle, MeasArm, MeasGate} meas_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  cmd_state_e  cmd_state_q, cmd_state_d;
  meas_state_e meas_state_q, meas_state_d;

  logic [1:0]  wr_addr_q;
  logic [4:0]  rd_addr_q;
  logic [31:0] gate_time_q, gate_time_d;
  logic [7:0]  rd_data_q, rd_byte;
  logic [31:0] rd_word;

  logic        wr_byte_en, rd_inc, wr_addr_clr, rd_addr_clr;

  logic [31:0] gate_len_q, ref_run_q, sig_run_q, seq_run_q;
  logic [31:0] res_ref_q, res_sig_q, res_seq_q;
  logic [31:0] pend_ref_q, pend_sig_q, pend_seq_q;
  logic        pend_vld_q;
  logic        latch_len, gate_start, meas_done, in_rd;
  logic [31:0] done_ref, done_sig, done_seq;

  logic        sig_sync_q, sig_dly_q, sig_edge;

  // ---------------------------------------------------------------------------------------------
  // Signal input conditioning and edge detection
  // ---------------------------------------------------------------------------------------------
`ifdef DFM_SIG_SYNC_EN
  logic sig_meta_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sig_meta_q <= 1'b0;
      sig_sync_q <= 1'b0;
      sig_dly_q  <= 1'b0;
    end else begin
      sig_meta_q <= sig_clk_i;
      sig_sync_q <= sig_meta_q;
      sig_dly_q  <= sig_sync_q;
    end
  end
`else
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sig_sync_q <= 1'b0;
      sig_dly_q  <= 1'b0;
    end else begin
      sig_sync_q <= sig_clk_i;
      sig_dly_q  <= sig_sync_q;
    end
  end
`endif

  assign sig_edge = sig_sync_q & ~sig_dly_q;

  // ---------------------------------------------------------------------------------------------
  // Command FSM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cmd_state_q <= StIdle;
    end else begin
      cmd_state_q <= cmd_state_d;
    end
  end

  always_comb begin
    cmd_state_d = cmd_state_q;
    if (spi_byte_vld_i && !dc_i) begin
      if (spi_byte_data_i == CMD_CONF_WR) begin
        cmd_state_d = StConfWr;
      end else if (spi_byte_data_i == CMD_REG_RD) begin
        cmd_state_d = StRegRd;
      end else begin
        cmd_state_d = StIdle;
      end
    end
  end

  always_comb begin
    wr_byte_en  = spi_byte_vld_i & dc_i & (cmd_state_q == StConfWr);
    rd_inc      = spi_byte_vld_i & dc_i & (cmd_state_q == StRegRd);
    wr_addr_clr = spi_byte_vld_i & ~dc_i & (spi_byte_data_i == CMD_CONF_WR);
    rd_addr_clr = spi_byte_vld_i & ~dc_i & (spi_byte_data_i == CMD_REG_RD);
  end

  always_comb begin
    gate_time_d = gate_time_q;
    if (wr_byte_en) begin
      gate_time_d[{wr_addr_q, 3'b000} +: 8] = spi_byte_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_addr_q   <= 2'd0;
      rd_addr_q   <= 5'd0;
      gate_time_q <= GATE_TIME_RST;
    end else begin
      gate_time_q <= gate_time_d;
      if (wr_addr_clr) begin
        wr_addr_q <= 2'd0;
      end else if (wr_byte_en) begin
        wr_addr_q <= wr_addr_q + 2'd1;
      end
      if (rd_addr_clr) begin
        rd_addr_q <= 5'd0;
      end else if (rd_inc) begin
        rd_addr_q <= rd_addr_q + 5'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Read map
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    case (rd_addr_q[4:2])
      3'd0:    rd_word = gate_time_q;
      3'd1:    rd_word = res_ref_q;
      3'd2:    rd_word = res_sig_q;
      3'd3:    rd_word = res_seq_q;
      default: rd_word = 32'd0;
    endcase
    rd_byte = rd_word[{rd_addr_q[1:0], 3'b000} +: 8];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= rd_byte;
    end
  end

  assign reg_rd_data_o   = rd_data_q;
  assign reg_gate_time_o = gate_time_q;

  // ---------------------------------------------------------------------------------------------
  // Measurement FSM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meas_state_q <= MeasIdle;
    end else begin
      meas_state_q <= meas_state_d;
    end
  end

  always_comb begin
    meas_state_d = meas_state_q;
    unique case (meas_state_q)
      MeasIdle: if (gate_time_q != 32'd0) meas_state_d = MeasArm;
      MeasArm:  if (sig_edge) meas_state_d = MeasGate;
      MeasGate: if (sig_edge && (ref_run_q >= gate_len_q)) meas_state_d = MeasIdle;
      default:  meas_state_d = MeasIdle;
    endcase
  end

  always_comb begin
    latch_len  = (meas_state_q == MeasIdle) && (gate_time_q != 32'd0);
    gate_start = (meas_state_q == MeasArm) && sig_edge;
    meas_done  = (meas_state_q == MeasGate) && sig_edge && (ref_run_q >= gate_len_q);
  end

  // The closing edge and its clock are counted in the published result.
  assign done_ref = sat_inc(ref_run_q);
  assign done_sig = sat_inc(sig_run_q);
  assign done_seq = sat_inc(seq_run_q);
  assign in_rd    = (cmd_state_q == StRegRd);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      gate_len_q <= 32'd0;
      ref_run_q  <= 32'd0;
      sig_run_q  <= 32'd0;
      seq_run_q  <= 32'd0;
    end else begin
      if (latch_len) begin
        gate_len_q <= gate_time_q;
      end
      if (gate_start) begin
        ref_run_q <= 32'd0;
        sig_run_q <= 32'd0;
      end else if (meas_state_q == MeasGate) begin
        ref_run_q <= sat_inc(ref_run_q);
        if (sig_edge) begin
          sig_run_q <= sat_inc(sig_run_q);
        end
      end
      if (meas_done) begin
        seq_run_q <= done_seq;
      end
    end
  end

  // Results stay frozen during a register read; the newest completion waits in one pending slot.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      res_ref_q  <= 32'd0;
      res_sig_q  <= 32'd0;
      res_seq_q  <= 32'd0;
      pend_ref_q <= 32'd0;
      pend_sig_q <= 32'd0;
      pend_seq_q <= 32'd0;
      pend_vld_q <= 1'b0;
    end else if (meas_done) begin
      if (in_rd) begin
        pend_ref_q <= done_ref;
        pend_sig_q <= done_sig;
        pend_seq_q <= done_seq;
        pend_vld_q <= 1'b1;
      end else begin
        res_ref_q  <= done_ref;
        res_sig_q  <= done_sig;
        res_seq_q  <= done_seq;
        pend_vld_q <= 1'b0;
      end
    end else if (pend_vld_q && !in_rd) begin
      res_ref_q  <= pend_ref_q;
      res_sig_q  <= pend_sig_q;
      res_seq_q  <= pend_seq_q;
      pend_vld_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dfm_core.sv
// Directed self-checking bench for dfm_core: command decode, gate_time writes, measurement
// results, read-map layout, read coherency and asynchronous reset.
`timescale 1ns/1ps
module tb_dfm_core;

  logic        clk;
  logic        rst_n;
  logic        dc;
  logic        vld;
  logic [7:0]  data;
  logic        sig_clk;
  logic [7:0]  rd_data;
  logic [31:0] gate_time;

  int          vectors;
  int          miscompares;
  int          cyc;
  int          sig_div;
  logic [7:0]  rbuf [0:47];
  logic [31:0] seq_a, seq_b;
  int          t0;

  dfm_core dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .dc_i            (dc),
    .spi_byte_vld_i  (vld),
    .spi_byte_data_i (data),
    .sig_clk_i       (sig_clk),
    .reg_rd_data_o   (rd_data),
    .reg_gate_time_o (gate_time)
  );

  initial clk = 1'b0;
  always #2.5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Signal under test: 100 clk periods, changing on the falling clk edge.
  initial begin
    sig_clk = 1'b0;
    sig_div = 0;
  end
  always @(negedge clk) begin
    if (sig_div == 49) begin
      sig_div <= 0;
      sig_clk <= ~sig_clk;
    end else begin
      sig_div <= sig_div + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Caller is at a falling edge; the byte is captured on the next rising edge.
  task automatic send_byte(input logic d, input logic [7:0] b);
    dc   = d;
    data = b;
    vld  = 1'b1;
    @(negedge clk);
    vld  = 1'b0;
    dc   = 1'b0;
    data = 8'h00;
  endtask

  task automatic read_bytes(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rbuf[base + i] = rd_data;
      send_byte(1'b1, 8'hFF);
    end
  endtask

  function automatic logic [31:0] word_at(input int a);
    return {rbuf[a + 3], rbuf[a + 2], rbuf[a + 1], rbuf[a]};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    dc    = 1'b0;
    vld   = 1'b0;
    data  = 8'h00;
    repeat (3) @(negedge clk);
    vectors++;
    if (rd_data !== 8'h00) begin
      $display("FAIL reset_rd_data_in_reset: got %h required %h", rd_data, 8'h00);
      miscompares++;
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (rd_data !== 8'h00) begin
      $display("FAIL reset_rd_data: got %h required %h", rd_data, 8'h00);
      miscompares++;
    end
    vectors++;
    if (gate_time !== 32'd0) begin
      $display("FAIL reset_gate_time: got %h required %h", gate_time, 32'd0);
      miscompares++;
    end
  endtask

  task automatic test_conf_write;
    send_byte(1'b0, 8'h2A);
    send_byte(1'b1, 8'h0A);
    vectors++;
    if (gate_time !== 32'h0000_000A) begin
      $display("FAIL conf_first_byte: got %h required %h", gate_time, 32'h0000_000A);
      miscompares++;
    end
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h00);
    vectors++;
    if (gate_time !== 32'h0000_000A) begin
      $display("FAIL conf_four_bytes: got %h required %h", gate_time, 32'h0000_000A);
      miscompares++;
    end
  endtask

  task automatic test_measure;
    repeat (450) @(negedge clk);
    send_byte(1'b0, 8'h3A);
    t0 = cyc;
    read_bytes(0, 16);
    send_byte(1'b0, 8'h00);
    seq_a = word_at(12);
    vectors++;
    if (word_at(0) !== 32'd10) begin
      $display("FAIL meas_gate_word: got %h required %h", word_at(0), 32'd10);
      miscompares++;
    end
    vectors++;
    if (word_at(4) !== 32'd100) begin
      $display("FAIL meas_ref_cnt: got %0d required %0d", word_at(4), 100);
      miscompares++;
    end
    vectors++;
    if (word_at(8) !== 32'd1) begin
      $display("FAIL meas_sig_cnt: got %0d required %0d", word_at(8), 1);
      miscompares++;
    end
    vectors++;
    if (seq_a == 32'd0) begin
      $display("FAIL meas_seq_nonzero: got %0d required nonzero", seq_a);
      miscompares++;
    end
    // A gate recurs every 200 clk, so re-entering exactly 200 clk later sees one more result.
    while (cyc < t0 + 199) @(negedge clk);
    send_byte(1'b0, 8'h3A);
    read_bytes(0, 16);
    send_byte(1'b0, 8'h00);
    seq_b = word_at(12);
    vectors++;
    if (seq_b !== seq_a + 32'd1) begin
      $display("FAIL meas_seq_step: got %0d required %0d", seq_b, seq_a + 32'd1);
      miscompares++;
    end
    vectors++;
    if (word_at(4) !== 32'd100) begin
      $display("FAIL meas_ref_cnt_2: got %0d required %0d", word_at(4), 100);
      miscompares++;
    end
  endtask

  task automatic test_read_map;
    logic [7:0] exp_b [0:11];
    exp_b = '{8'h0A, 8'h00, 8'h00, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00,
              8'h01, 8'h00, 8'h00, 8'h00};
    send_byte(1'b0, 8'h3A);
    read_bytes(0, 12);
    send_byte(1'b0, 8'h00);
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if (rbuf[i] !== exp_b[i]) begin
        $display("FAIL read_map_byte%0d: got %h required %h", i, rbuf[i], exp_b[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_coherency;
    send_byte(1'b0, 8'h3A);
    t0 = cyc;
    read_bytes(0, 16);
    seq_a = word_at(12);
    while (cyc < t0 + 250) @(negedge clk);
    read_bytes(16, 16);
    read_bytes(32, 16);
    send_byte(1'b0, 8'h00);
    for (int i = 16; i < 32; i++) begin
      vectors++;
      if (rbuf[i] !== 8'h00) begin
        $display("FAIL coh_unused_byte%0d: got %h required %h", i, rbuf[i], 8'h00);
        miscompares++;
      end
    end
    vectors++;
    if (word_at(44) !== seq_a) begin
      $display("FAIL coh_seq_frozen: got %0d required %0d", word_at(44), seq_a);
      miscompares++;
    end
    vectors++;
    if (word_at(36) !== 32'd100) begin
      $display("FAIL coh_ref_wrapped: got %0d required %0d", word_at(36), 100);
      miscompares++;
    end
    // Two gates complete in a 400 clk window; the newer one must be visible.
    while (cyc < t0 + 399) @(negedge clk);
    send_byte(1'b0, 8'h3A);
    read_bytes(0, 16);
    send_byte(1'b0, 8'h00);
    vectors++;
    if (word_at(12) !== seq_a + 32'd2) begin
      $display("FAIL coh_seq_after_exit: got %0d required %0d", word_at(12), seq_a + 32'd2);
      miscompares++;
    end
    vectors++;
    if (word_at(8) !== 32'd1) begin
      $display("FAIL coh_sig_after_exit: got %0d required %0d", word_at(8), 1);
      miscompares++;
    end
  endtask

  task automatic test_ignore_and_wrap;
    send_byte(1'b0, 8'h55);
    send_byte(1'b1, 8'h11);
    vectors++;
    if (gate_time !== 32'h0000_000A) begin
      $display("FAIL ignore_unknown_cmd: got %h required %h", gate_time, 32'h0000_000A);
      miscompares++;
    end
    send_byte(1'b0, 8'h2A);
    send_byte(1'b1, 8'h05);
    send_byte(1'b1, 8'h12);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h00);
    vectors++;
    if (gate_time !== 32'h0000_1205) begin
      $display("FAIL wrap_four_bytes: got %h required %h", gate_time, 32'h0000_1205);
      miscompares++;
    end
    send_byte(1'b1, 8'h0A);
    vectors++;
    if (gate_time !== 32'h0000_120A) begin
      $display("FAIL wrap_fifth_byte: got %h required %h", gate_time, 32'h0000_120A);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (gate_time !== 32'd0) begin
      $display("FAIL midreset_gate_async: got %h required %h", gate_time, 32'd0);
      miscompares++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(1'b0, 8'h3A);
    read_bytes(0, 16);
    send_byte(1'b0, 8'h00);
    for (int w = 0; w < 4; w++) begin
      vectors++;
      if (word_at(4 * w) !== 32'd0) begin
        $display("FAIL midreset_word%0d: got %h required %h", w, word_at(4 * w), 32'd0);
        miscompares++;
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_conf_write();
    test_measure();
    test_read_map();
    test_coherency();
    test_ignore_and_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
